// File: rtl/tpa_pkg.sv
// tpa_pkg: shared types for the tpa_param register file.
//   rim_state_e - register-interface FSM states
//   twp_state_e - two-wire-protocol slave FSM states
//   win_e       - which side started most recently (collision winner)
//   in_range()  - address bound check against the implemented depth
package tpa_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_SET,
        R_ACC
    } rim_state_e;

    typedef enum logic [3:0] {
        T_IDLE,
        T_CMD,
        T_ADDR,
        T_WDATA,
        T_COMMIT,
        T_TA1,
        T_TA2,
        T_START,
        T_RDATA
    } twp_state_e;

    typedef enum logic {
        WIN_RIM = 1'b0,
        WIN_TWP = 1'b1
    } win_e;

    function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/tpa_twp_slave.sv
// tpa_twp_slave: serial two-wire-protocol slave, one bit per clk cycle.
//   clk, reset_n  - clock, async active-low reset
//   sda           - bidirectional data pin, released unless driving
//   start_o       - high in the cycle the start bit (SDA=0 in IDLE) is sampled
//   wr_o          - write-commit strobe (COMMIT state); addr_o / wdata_o valid
//   rd_o          - read strobe (START state); rdata_i is latched at its end
//   addr_o        - received address
//   wdata_o       - received write data
//   rdata_i       - register value to return (top supplies 0 when out of range)
module tpa_twp_slave
    import tpa_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    inout  wire               sda,
    output logic              start_o,
    output logic              wr_o,
    output logic              rd_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic [DATA_W-1:0] rdata_i
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W);

    twp_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              sda_in, sda_oe, sda_out;

    assign sda_in  = sda;
    assign sda     = sda_oe ? sda_out : 1'bz;
    assign addr_o  = addr_q;
    assign wdata_o = data_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sda_oe  = 1'b0;
        sda_out = 1'b0;
        start_o = 1'b0;
        wr_o    = 1'b0;
        rd_o    = 1'b0;
        unique case (state_q)
            T_IDLE: begin
                if (!sda_in) begin
                    start_o = 1'b1;
                    state_d = T_CMD;
                end
            end
            T_CMD: begin
                cmd_d   = sda_in;
                cnt_d   = CNT_W'(ADDR_W - 1);
                state_d = T_ADDR;
            end
            T_ADDR: begin
                // LSB first: shift new bits in at the top, moving right
                addr_d = ADDR_W'({sda_in, addr_q} >> 1);
                if (cnt_q == '0) begin
                    if (cmd_q) begin
                        cnt_d   = CNT_W'(DATA_W - 1);
                        state_d = T_WDATA;
                    end else begin
                        state_d = T_TA1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            T_WDATA: begin
                data_d = DATA_W'({sda_in, data_q} >> 1);
                if (cnt_q == '0) state_d = T_COMMIT;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            T_COMMIT: begin
                wr_o    = 1'b1;
                state_d = T_IDLE;
            end
            T_TA1: state_d = T_TA2;
            T_TA2: begin
                sda_oe  = 1'b1;
                sda_out = 1'b1;
                state_d = T_START;
            end
            T_START: begin
                sda_oe  = 1'b1;
                sda_out = 1'b0;
                rd_o    = 1'b1;
                data_d  = rdata_i;
                cnt_d   = CNT_W'(DATA_W - 1);
                state_d = T_RDATA;
            end
            T_RDATA: begin
                sda_oe  = 1'b1;
                sda_out = data_q[0];
                data_d  = data_q >> 1;
                if (cnt_q == '0) state_d = T_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= T_IDLE;
            cnt_q   <= '0;
            cmd_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/tpa_param.sv
// tpa_param: parametrised register file shared by a register-interface master
// (cfg_* handshake) and a two-wire-protocol slave (SDA).
//   clk, reset_n        - clock, async active-low reset
//   SCL                 - pin-compatibility only, unused
//   SDA                 - TWP data pin
//   cfg_req/cmd/addr/wdata - RIM request, held until cfg_rdy (cmd 1 = write)
//   cfg_rdy             - one-cycle completion pulse
//   cfg_rdata           - read data, held after cfg_rdy
//   cfg_err             - pulses with cfg_rdy for out-of-range addresses
module tpa_param
    import tpa_pkg::*;
#(
    parameter int          DATA_W = 16,
    parameter int          ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              SCL,
    inout  wire               SDA,
    input  logic              cfg_req,
    input  logic              cfg_cmd,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic              cfg_rdy,
    output logic [DATA_W-1:0] cfg_rdata,
    output logic              cfg_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    rim_state_e        rim_state_q, rim_state_d;
    logic              rim_hold_q;
    logic              rim_cmd_q, rim_cmd_d;
    logic [ADDR_W-1:0] rim_addr_q, rim_addr_d;
    logic [DATA_W-1:0] rim_wdata_q, rim_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rim_acc, rim_in;
    win_e              last_q, last_d;

    logic              twp_start, twp_wr, twp_rd, twp_in;
    logic [ADDR_W-1:0] twp_addr;
    logic [DATA_W-1:0] twp_wdata, twp_rdata;

    logic              rim_we_raw, twp_we_raw, clash, rim_we, twp_we;
    logic              unused_scl;

    assign unused_scl = SCL;

    tpa_twp_slave #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_twp (
        .clk     (clk),
        .reset_n (reset_n),
        .sda     (SDA),
        .start_o (twp_start),
        .wr_o    (twp_wr),
        .rd_o    (twp_rd),
        .addr_o  (twp_addr),
        .wdata_o (twp_wdata),
        .rdata_i (twp_rdata)
    );

    assign rim_in    = in_range(32'(rim_addr_q), DEPTH);
    assign twp_in    = in_range(32'(twp_addr), DEPTH);
    assign twp_rdata = twp_in ? mem_q[twp_addr[IDX_W-1:0]] : '0;

    assign cfg_rdy   = (rim_state_q == R_ACC);
    assign cfg_err   = cfg_rdy && !rim_in;
    assign cfg_rdata = rdata_q;

    // Same-address write collision: the side that started later keeps its
    // write. RIM acceptance takes precedence when both start together.
    assign rim_we_raw = (rim_state_q == R_ACC) && rim_cmd_q && rim_in;
    assign twp_we_raw = twp_wr && twp_in;
    assign clash      = rim_we_raw && twp_we_raw && (rim_addr_q == twp_addr);
    assign rim_we     = rim_we_raw && !(clash && last_q == WIN_TWP);
    assign twp_we     = twp_we_raw && !(clash && last_q == WIN_RIM);

    always_comb begin
        last_d = last_q;
        if (rim_acc)        last_d = WIN_RIM;
        else if (twp_start) last_d = WIN_TWP;
    end

    always_comb begin
        rim_state_d = rim_state_q;
        rim_cmd_d   = rim_cmd_q;
        rim_addr_d  = rim_addr_q;
        rim_wdata_d = rim_wdata_q;
        rdata_d     = rdata_q;
        rim_acc     = 1'b0;
        unique case (rim_state_q)
            R_IDLE: begin
                // rim_hold_q enforces one idle cycle after each completion
                if (cfg_req && !rim_hold_q) begin
                    rim_acc     = 1'b1;
                    rim_cmd_d   = cfg_cmd;
                    rim_addr_d  = cfg_addr;
                    rim_wdata_d = cfg_wdata;
                    rim_state_d = R_SET;
                end
            end
            R_SET: begin
                // Sampled before any write landing on this same edge
                if (!rim_cmd_q) rdata_d = rim_in ? mem_q[rim_addr_q[IDX_W-1:0]] : '0;
                rim_state_d = R_ACC;
            end
            R_ACC:   rim_state_d = R_IDLE;
            default: rim_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rim_state_q <= R_IDLE;
            rim_hold_q  <= 1'b0;
            rim_cmd_q   <= 1'b0;
            rim_addr_q  <= '0;
            rim_wdata_q <= '0;
            rdata_q     <= '0;
            last_q      <= WIN_RIM;
        end else begin
            rim_state_q <= rim_state_d;
            rim_hold_q  <= (rim_state_q == R_ACC);
            rim_cmd_q   <= rim_cmd_d;
            rim_addr_q  <= rim_addr_d;
            rim_wdata_q <= rim_wdata_d;
            rdata_q     <= rdata_d;
            last_q      <= last_d;
        end
    end

    // Storage is deliberately not reset; write enables derive from reset
    // state registers, so nothing in flight lands while reset_n is low.
    always_ff @(posedge clk) begin
        if (rim_we) mem_q[rim_addr_q[IDX_W-1:0]] <= rim_wdata_q;
        if (twp_we) mem_q[twp_addr[IDX_W-1:0]]   <= twp_wdata;
    end

endmodule

// File: tb/tb_tpa_param.sv
module tb_tpa_param;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    wire sda1, sda2;
    logic [1:0] tb_oe = '0;
    logic [1:0] tb_o = '0;
    assign sda1 = tb_oe[0] ? tb_o[0] : 1'bz;
    assign sda2 = tb_oe[1] ? tb_o[1] : 1'bz;
    pullup (sda1);
    pullup (sda2);

    logic        cfg_req = 1'b0, cfg_cmd = 1'b0;
    logic [7:0]  cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    logic        cfg_rdy, cfg_err;
    logic [15:0] cfg_rdata;
    logic        c2_rdy, c2_err;
    logic [7:0]  c2_rdata;

    tpa_param #(.DATA_W(16), .ADDR_W(8), .DEPTH(200)) dut (
        .clk(clk), .reset_n(reset_n), .SCL(1'b1), .SDA(sda1),
        .cfg_req(cfg_req), .cfg_cmd(cfg_cmd), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdy(cfg_rdy), .cfg_rdata(cfg_rdata), .cfg_err(cfg_err)
    );

    tpa_param #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut2 (
        .clk(clk), .reset_n(reset_n), .SCL(1'b1), .SDA(sda2),
        .cfg_req(1'b0), .cfg_cmd(1'b0), .cfg_addr(4'h0), .cfg_wdata(8'h00),
        .cfg_rdy(c2_rdy), .cfg_rdata(c2_rdata), .cfg_err(c2_err)
    );

    typedef struct {
        int          cyc;
        logic        wr;
        logic [15:0] d;
        logic        err;
    } rim_exp_t;

    rim_exp_t    rim_q[$];
    logic [15:0] twp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic obs(input int sel);
        return (sel == 0) ? sda1 : sda2;
    endfunction

    // RIM completion monitor: pops the scoreboard on every cfg_rdy
    always @(negedge clk) begin
        if (reset_n && cfg_rdy) begin
            if (rim_q.size() == 0) begin
                chk("rim_spurious", 32'(cfg_rdy), 0);
            end else begin
                rim_exp_t e;
                e = rim_q.pop_front();
                chk("rim_lat", cyc, e.cyc);
                chk("rim_err", 32'(cfg_err), 32'(e.err));
                if (!e.wr) chk("rim_rdata", 32'(cfg_rdata), 32'(e.d));
            end
        end
    end

    task automatic rim_go(input logic cmd, input logic [7:0] a, input logic [15:0] wd,
                          input logic [15:0] ed, input logic ee);
        rim_exp_t e;
        bit got;
        e.cyc = cyc + 2; e.wr = cmd; e.d = ed; e.err = ee;
        rim_q.push_back(e);
        cfg_req = 1'b1; cfg_cmd = cmd; cfg_addr = a; cfg_wdata = wd;
        got = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cfg_rdy) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk("rim_timeout", 0, 1);
            void'(rim_q.pop_back());
        end
        tick();
        cfg_req = 1'b0;
        tick();
    endtask

    task automatic twp_hdr(input int sel, input logic cmd, input int aw, input logic [7:0] a);
        tb_oe[sel] = 1'b1;
        tb_o[sel] = 1'b0;
        tick();
        tb_o[sel] = cmd;
        tick();
        for (int i = 0; i < aw; i++) begin
            tb_o[sel] = a[i];
            tick();
        end
    endtask

    task automatic twp_write(input int sel, input int aw, input int dw,
                             input logic [7:0] a, input logic [15:0] d);
        twp_hdr(sel, 1'b1, aw, a);
        for (int i = 0; i < dw; i++) begin
            tb_o[sel] = d[i];
            tick();
        end
        tb_oe[sel] = 1'b0;
        tick();
    endtask

    task automatic twp_read(input int sel, input int aw, input int dw,
                            input logic [7:0] a, input logic [15:0] exp);
        logic [15:0] w;
        logic [15:0] e;
        twp_q.push_back(exp);
        twp_hdr(sel, 1'b0, aw, a);
        tb_oe[sel] = 1'b0;
        @(negedge clk); chk("twp_ta1", 32'(obs(sel)), 1); tick();
        @(negedge clk); chk("twp_ta2", 32'(obs(sel)), 1); tick();
        @(negedge clk); chk("twp_start", 32'(obs(sel)), 0); tick();
        w = '0;
        for (int i = 0; i < dw; i++) begin
            @(negedge clk);
            w[i] = obs(sel);
            tick();
        end
        @(negedge clk); chk("twp_release", 32'(obs(sel)), 1); tick();
        e = twp_q.pop_front();
        chk("twp_rdata", 32'(w), 32'(e));
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_rdy", 32'(cfg_rdy), 0);
        chk("rst_rdata", 32'(cfg_rdata), 0);
        chk("rst_err", 32'(cfg_err), 0);
        chk("rst_sda1", 32'(sda1), 1);
        chk("rst_sda2", 32'(sda2), 1);
        reset_n = 1'b1;
        tick();

        // basic RIM and TWP round trips
        rim_go(1, 8'h10, 16'hA5A5, 16'h0, 0);
        rim_go(0, 8'h10, 16'h0, 16'hA5A5, 0);
        twp_write(0, 8, 16, 8'h20, 16'h1234);
        twp_read(0, 8, 16, 8'h20, 16'h1234);
        rim_go(0, 8'h20, 16'h0, 16'h1234, 0);
        twp_write(0, 8, 16, 8'h10, 16'h0F0F);
        rim_go(0, 8'h10, 16'h0, 16'h0F0F, 0);
        rim_go(1, 8'h10, 16'hA5A5, 16'h0, 0);

        // range boundary with DEPTH=200
        rim_go(1, 8'hF0, 16'h7777, 16'h0, 1);
        rim_go(0, 8'hF0, 16'h0, 16'h0, 1);
        twp_write(0, 8, 16, 8'hF0, 16'hFFFF);
        twp_read(0, 8, 16, 8'hF0, 16'h0000);
        rim_go(1, 8'hC7, 16'hC7C7, 16'h0, 0);
        rim_go(0, 8'hC7, 16'h0, 16'hC7C7, 0);
        rim_go(0, 8'hC8, 16'h0, 16'h0, 1);

        // RIM ACC shares the cycle with TWP COMMIT; RIM started later and wins
        fork
            twp_write(0, 8, 16, 8'h30, 16'h1111);
            begin repeat (24) tick(); rim_go(1, 8'h30, 16'h2222, 16'h0, 0); end
        join
        rim_go(0, 8'h30, 16'h0, 16'h2222, 0);
        // RIM ACC one cycle before COMMIT: no clash, TWP lands last
        fork
            twp_write(0, 8, 16, 8'h30, 16'h1111);
            begin repeat (23) tick(); rim_go(1, 8'h30, 16'h3333, 16'h0, 0); end
        join
        rim_go(0, 8'h30, 16'h0, 16'h1111, 0);

        // RIM read sampled in the COMMIT cycle sees the old value
        rim_go(1, 8'h40, 16'h0F0F, 16'h0, 0);
        fork
            twp_write(0, 8, 16, 8'h40, 16'hBEEF);
            begin repeat (25) tick(); rim_go(0, 8'h40, 16'h0, 16'h0F0F, 0); end
        join
        rim_go(0, 8'h40, 16'h0, 16'hBEEF, 0);

        // TWP START latches the old value while RIM ACC writes
        rim_go(1, 8'h50, 16'h5555, 16'h0, 0);
        fork
            twp_read(0, 8, 16, 8'h50, 16'h5555);
            begin repeat (10) tick(); rim_go(1, 8'h50, 16'h6666, 16'h0, 0); end
        join
        rim_go(0, 8'h50, 16'h0, 16'h6666, 0);

        // reset during TWP WDATA
        twp_hdr(0, 1'b1, 8, 8'h20);
        for (int i = 0; i < 4; i++) begin
            tb_o[0] = 1'b1;
            tick();
        end
        reset_n = 1'b0;
        tb_oe[0] = 1'b0;
        #2;
        chk("rstw_rdy", 32'(cfg_rdy), 0);
        chk("rstw_rdata", 32'(cfg_rdata), 0);
        chk("rstw_err", 32'(cfg_err), 0);
        chk("rstw_sda", 32'(sda1), 1);
        tick();
        reset_n = 1'b1;
        tick();
        rim_go(0, 8'h20, 16'h0, 16'h1234, 0);

        // reset during RIM SET
        cfg_req = 1'b1; cfg_cmd = 1'b1; cfg_addr = 8'h10; cfg_wdata = 16'hDEAD;
        tick();
        reset_n = 1'b0;
        #2;
        chk("rsts_rdy", 32'(cfg_rdy), 0);
        chk("rsts_rdata", 32'(cfg_rdata), 0);
        cfg_req = 1'b0;
        tick(); tick();
        chk("rsts_rdy2", 32'(cfg_rdy), 0);
        reset_n = 1'b1;
        tick();
        rim_go(0, 8'h10, 16'h0, 16'hA5A5, 0);

        // reset during TWP RDATA releases SDA at once
        twp_hdr(0, 1'b0, 8, 8'h50);
        tb_oe[0] = 1'b0;
        tick(); tick(); tick();
        @(negedge clk);
        chk("rstr_bit0", 32'(sda1), 0);
        reset_n = 1'b0;
        #1;
        chk("rstr_sda", 32'(sda1), 1);
        tick();
        reset_n = 1'b1;
        tick();
        twp_read(0, 8, 16, 8'h50, 16'h6666);

        // narrow instance: 8-bit data, 4-bit address, 16 entries
        twp_write(1, 4, 8, 8'h05, 16'h003C);
        twp_write(1, 4, 8, 8'h0F, 16'h00A1);
        twp_read(1, 4, 8, 8'h05, 16'h003C);
        twp_read(1, 4, 8, 8'h0F, 16'h00A1);
        chk("n_rdy", 32'(c2_rdy), 0);
        chk("n_rdata", 32'(c2_rdata), 0);
        chk("n_err", 32'(c2_err), 0);

        chk("rim_q_left", rim_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
